// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: execute stage plus EX/MEM pipeline register.
// Decodes the ID-stage bundle, computes the logic/shift result, and registers
// it as ex_* (first forwarding source). It then delays it one cycle as mem_*
// (second forwarding source and register-file write port).
//
// Optional feature macro: EX_SERIAL_SHIFT_EN
//   undefined : single-cycle barrel shifter, stall_o tied low.
//   defined   : shifts with a nonzero amount run one bit per cycle through a
//               small IDLE/SHIFT FSM. stall_o is high while shifting.
//
// Serial shifter states (EX_SERIAL_SHIFT_EN only):
//   state | meaning
//   IDLE  | accepting a new bundle every edge
//   SHIFT | serial shift in progress, inputs ignored, ex_we held low
module ex_mem_pipe (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  alusel_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_data_i,
    input  logic [31:0] reg2_data_i,
    input  logic        wreg_i,
    input  logic [4:0]  waddr_i,
    output logic        ex_we,
    output logic [4:0]  ex_waddr,
    output logic [31:0] ex_wdata,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        stall_o
);

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    localparam logic [1:0] SH_LL = 2'd0;
    localparam logic [1:0] SH_RL = 2'd1;
    localparam logic [1:0] SH_RA = 2'd2;

    logic        op_known;
    logic        op_is_shift;
    logic [1:0]  sh_kind;
    logic [4:0]  sh_amt;
    logic [31:0] op_result;

    logic        ex_we_q,    ex_we_d;
    logic [4:0]  ex_waddr_q, ex_waddr_d;
    logic [31:0] ex_wdata_q, ex_wdata_d;
    logic        mem_we_q,    mem_we_d;
    logic [4:0]  mem_waddr_q, mem_waddr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    assign sh_amt = reg1_data_i[4:0];

`ifndef EX_SERIAL_SHIFT_EN
    function automatic logic [31:0] barrel(input logic [31:0] val,
                                           input logic [4:0]  n,
                                           input logic [1:0]  kind);
        logic [31:0] r;
        case (kind)
            SH_LL:   r = val << n;
            SH_RL:   r = val >> n;
            default: r = $unsigned($signed(val) >>> n);
        endcase
        return r;
    endfunction
`endif

    // Decode alusel/aluop into a known flag, shift kind and single-cycle result.
    always_comb begin
        op_known    = 1'b0;
        op_is_shift = 1'b0;
        sh_kind     = SH_LL;
        op_result   = 32'h0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    8'h24, 8'h0C: begin op_known = 1'b1; op_result = reg1_data_i & reg2_data_i; end
                    8'h25, 8'h0D: begin op_known = 1'b1; op_result = reg1_data_i | reg2_data_i; end
                    8'h26, 8'h0E: begin op_known = 1'b1; op_result = reg1_data_i ^ reg2_data_i; end
                    8'h27:        begin op_known = 1'b1; op_result = ~(reg1_data_i | reg2_data_i); end
                    8'h0F:        begin op_known = 1'b1; op_result = {reg2_data_i[15:0], 16'h0000}; end
                    default: ;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    8'h00, 8'h04: begin op_known = 1'b1; op_is_shift = 1'b1; sh_kind = SH_LL; end
                    8'h02, 8'h06: begin op_known = 1'b1; op_is_shift = 1'b1; sh_kind = SH_RL; end
                    8'h03, 8'h07: begin op_known = 1'b1; op_is_shift = 1'b1; sh_kind = SH_RA; end
                    default: ;
                endcase
                if (op_is_shift) begin
`ifdef EX_SERIAL_SHIFT_EN
                    // Only zero-amount shifts take the single-cycle path here.
                    op_result = reg2_data_i;
`else
                    op_result = barrel(reg2_data_i, sh_amt, sh_kind);
`endif
                end
            end
            default: ;
        endcase
    end

    // MEM register simply follows EX; it is never stalled.
    always_comb begin
        mem_we_d    = ex_we_q;
        mem_waddr_d = ex_waddr_q;
        mem_wdata_d = ex_wdata_q;
    end

`ifdef EX_SERIAL_SHIFT_EN

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t      state_q,  state_d;
    logic [31:0] work_q,   work_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [1:0]  kind_q,   kind_d;
    logic [4:0]  lwaddr_q, lwaddr_d;
    logic        lwe_q,    lwe_d;
    logic [31:0] work_step;

    function automatic logic [31:0] step1(input logic [31:0] w, input logic [1:0] kind);
        logic [31:0] r;
        case (kind)
            SH_LL:   r = {w[30:0], 1'b0};
            SH_RL:   r = {1'b0, w[31:1]};
            default: r = {w[31], w[31:1]};
        endcase
        return r;
    endfunction

    assign work_step = step1(work_q, kind_q);

    // Next-state and EX register values for the serial shifter FSM.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        kind_d     = kind_q;
        lwaddr_d   = lwaddr_q;
        lwe_d      = lwe_q;
        ex_we_d    = wreg_i && op_known && (waddr_i != 5'd0);
        ex_waddr_d = waddr_i;
        ex_wdata_d = op_result;
        case (state_q)
            IDLE: begin
                if (op_is_shift && (sh_amt != 5'd0)) begin
                    work_d     = reg2_data_i;
                    cnt_d      = sh_amt;
                    kind_d     = sh_kind;
                    lwaddr_d   = waddr_i;
                    lwe_d      = wreg_i && (waddr_i != 5'd0);
                    ex_we_d    = 1'b0;
                    ex_waddr_d = 5'd0;
                    ex_wdata_d = 32'h0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    ex_we_d    = lwe_q;
                    ex_waddr_d = lwaddr_q;
                    ex_wdata_d = work_step;
                    state_d    = IDLE;
                end else begin
                    ex_we_d    = 1'b0;
                    ex_waddr_d = 5'd0;
                    ex_wdata_d = 32'h0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, shifter datapath and pipeline registers; reset abandons a shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            work_q      <= 32'h0;
            cnt_q       <= 5'd0;
            kind_q      <= SH_LL;
            lwaddr_q    <= 5'd0;
            lwe_q       <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_waddr_q  <= 5'd0;
            ex_wdata_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= 5'd0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            lwaddr_q    <= lwaddr_d;
            lwe_q       <= lwe_d;
            ex_we_q     <= ex_we_d;
            ex_waddr_q  <= ex_waddr_d;
            ex_wdata_q  <= ex_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign stall_o = (state_q == SHIFT);

`else

    // EX register takes the new bundle every edge; r0 writes never announced.
    always_comb begin
        ex_we_d    = wreg_i && op_known && (waddr_i != 5'd0);
        ex_waddr_d = waddr_i;
        ex_wdata_d = op_result;
    end

    // EX and MEM pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_we_q     <= 1'b0;
            ex_waddr_q  <= 5'd0;
            ex_wdata_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= 5'd0;
            mem_wdata_q <= 32'h0;
        end else begin
            ex_we_q     <= ex_we_d;
            ex_waddr_q  <= ex_waddr_d;
            ex_wdata_q  <= ex_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign stall_o = 1'b0;

`endif

    assign ex_we     = ex_we_q;
    assign ex_waddr  = ex_waddr_q;
    assign ex_wdata  = ex_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Execute stage plus EX/MEM pipeline register for the five-stage MIPS core. It consumes the registered decode bundle from the ID stage (alusel, aluop, two operands, write-enable, write address), computes the logic/shift result, and registers it as the ex_* result. It delays that result one more cycle as mem_*. These are the two forwarding sources the ID stage compares against, and mem_* also drives the register-file write port.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- alusel_i  input  3  operation class: 3'b000 nop, 3'b001 logic, 3'b010 shift.
- aluop_i  input  8  operation code within the class.
- reg1_data_i  input  32  operand 1: rs value, or zero-extended shamt for immediate shifts.
- reg2_data_i  input  32  operand 2: rt value, or zero-extended imm16 for immediate ops.
- wreg_i  input  1  instruction writes a GPR.
- waddr_i  input  5  destination GPR.
- ex_we  output  1  EX result valid for write and forwarding.
- ex_waddr  output  5  EX destination.
- ex_wdata  output  32  EX result.
- mem_we  output  1  MEM-stage write enable; also the register-file write enable.
- mem_waddr  output  5  MEM destination.
- mem_wdata  output  32  MEM result.
- stall_o  output  1  execute busy; upstream must hold its bundle stable.

## Operation
- **Logic ops (alusel 001):**
  - 0x24 / 0x0C: and.
  - 0x25 / 0x0D: or.
  - 0x26 / 0x0E: xor.
  - 0x27: nor.
  - 0x0F (lui): result = {reg2[15:0], 16'h0000}.
- **Shift ops (alusel 010):** shifted value = reg2; amount n = reg1[4:0].
  - 0x00 / 0x04: logical left (sll, sllv).
  - 0x02 / 0x06: logical right (srl, srlv).
  - 0x03 / 0x07: arithmetic right (sra, srav).
- **Nop and unknown codes:** alusel 000, or any unlisted alusel/aluop pair, gives result 0 and ex_we 0.
- **Write enable:** ex_we = wreg_i AND known op AND waddr_i != 0. Writes to r0 are never announced, so ID never forwards into r0.
- **EX register update:** ex_waddr <= waddr_i; ex_wdata <= result. The update happens on every edge where the block is idle.
- **MEM register update:** on every edge, mem_* <= ex_*. The MEM register is never stalled.

## Timing
- **Reset:** all outputs 0 (ex_we, ex_waddr, ex_wdata, mem_we, mem_waddr, mem_wdata, stall_o). The shift FSM returns to IDLE. An asynchronous reset mid-shift abandons the operation; no write is produced.
- **Default latency:** the bundle sampled at edge k appears on ex_* after edge k and on mem_* after edge k+1.
- **Back-to-back:** a new bundle is accepted on every edge; there are no bubbles.
- **Stall:** stall_o is 0 whenever the serial shifter is compiled out.

## Configuration
- **Macro:** EX_SERIAL_SHIFT_EN.
- **Without the macro:** single-cycle barrel shifter; stall_o tied to 0.
- **With the macro:** shifts run one bit per cycle through FSM states IDLE and SHIFT.
  - **Amount 0:** a shift with n = 0 completes like a logic op (result = reg2, latency 1).
  - **Start (n > 0):** a shift with n > 0 sampled in IDLE at edge k loads work = reg2, cnt = n, and latches op and waddr. The FSM enters SHIFT and sets ex_we <= 0, a bubble.
  - **Stall window:** stall_o = (state == SHIFT), combinational from state. Inputs are ignored while in SHIFT.
  - **Each SHIFT edge:** work shifts by one bit (sra replicates bit 31); cnt decrements.
  - **Completion:** the edge where cnt == 1 writes the final value and latched waddr/we to ex_*, then returns to IDLE.
  - **Resulting timing:** the result is on ex_* after edge k+n. stall_o is high from after edge k until after edge k+n. The next bundle is sampled at edge k+n+1.
  - **MEM during a serial shift:** mem_* receives bubbles (mem_we 0) during the shift.

## Test plan
- **ori/or/nor:** ori with reg1=0x1234_0000, reg2=0x0000_00FF, waddr 3 -> ex_we=1, ex_waddr=3, ex_wdata=0x1234_00FF. The next cycle shows mem_* with the same values. nor of 0xF0F0_F0F0 and 0x0F0F_0000 -> 0x0000_0F0F.
- **lui and r0 suppression:** lui with reg2=0xABCD, waddr 5 -> ex_wdata=0xABCD_0000. The same op with waddr 0 -> ex_we=0.
- **Shifts, barrel build:**
  - sra: reg1=4, reg2=0x8000_0010 -> 0xF800_0001.
  - srlv: reg1=0x24 (n=4), same reg2 -> 0x0800_0001.
  - sll: reg1=31, reg2=1 -> 0x8000_0000.
- **Back-to-back and nop:** a nop (alusel 000, wreg 1) -> ex_we=0, ex_wdata=0. Four consecutive logic ops produce four consecutive ex_* results and then mem_* results, with no gaps.
- **Serial build (EX_SERIAL_SHIFT_EN):** sll with n=3, reg2=1, waddr 7 -> stall_o high for 3 cycles and ex_we=0 during those cycles. Then ex_wdata=0x8, ex_we=1, ex_waddr=7, and stall_o low. Inputs changed mid-shift are ignored.
- **Reset mid-operation:** assert reset_n low during a serial shift with n=20 -> all outputs go to 0 immediately. After release, ex_we=0 and the FSM is in IDLE; the next ori executes with latency 1.
